// File: rtl/ldpc_mem_pkg.sv
// Shared constants and types for the LDPC on-chip word storage.
//   DATA_W : word width in bits
//   ADDR_W : address width in bits
//   DEPTH  : number of words (always 2**ADDR_W)
package ldpc_mem_pkg;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/spram_core.sv
// Pure inferred single-port RAM, write-first, registered read, no reset.
//   clk  : rising-edge clock
//   en   : port enable (no access and q holds when low)
//   we   : write enable, qualified by en
//   addr : word address
//   din  : write data
//   q    : registered read data (write data on a write edge)
import ldpc_mem_pkg::*;

module spram_core (
  input  logic  clk,
  input  logic  en,
  input  logic  we,
  input  addr_t addr,
  input  word_t din,
  output word_t q
);

  // Declaration initialiser gives the all-zero power-up image.
  word_t mem [DEPTH] = '{default: '0};
  word_t q_r = '0;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
        q_r       <= din;
      end else begin
        q_r       <= mem[addr];
      end
    end
  end

  assign q = q_r;

endmodule

// File: rtl/matrix_multip.sv
// 4096 x 20 single-port block-RAM wrapper with enable, write enable,
// write-first registered read and an asynchronously cleared output.
//   clk      : rising-edge clock
//   rst_n    : async active-low reset, clears data_out, blocks access
//   addr     : word address (read and write)
//   data_in  : write data
//   data_out : registered read data
//   core_en  : port enable
//   wr_en    : write enable, qualified by core_en
import ldpc_mem_pkg::*;

module matrix_multip (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              core_en,
  input  logic              wr_en
);

  logic  run;   // access allowed; re-armed by the first edge after release
  logic  clr;   // data_out forced to 0 until the next real access
  logic  en;
  word_t q;

  // rst_n never feeds the RAM directly, only through flops it resets;
  // the release edge itself performs no access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign en = run & core_en;

  // The RAM register itself cannot be reset, so the clear is a mask that
  // falls away on the first enabled access, which also reloads q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  clr <= 1'b1;
    else if (en) clr <= 1'b0;
  end

  spram_core u_core (
    .clk  (clk),
    .en   (en),
    .we   (wr_en),
    .addr (addr),
    .din  (data_in),
    .q    (q)
  );

  assign data_out = clr ? '0 : q;

endmodule

// File: tb/tb_matrix_multip.sv
module tb_matrix_multip;
  localparam int DW = 20;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          core_en = 1'b0;
  logic          wr_en = 1'b0;

  typedef struct {
    logic [DW-1:0] v;
    string         n;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  event chk_now;

  always #5 clk = ~clk;

  matrix_multip dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .core_en  (core_en),
    .wr_en    (wr_en)
  );

  // Monitor: after each rising edge (or an immediate-check request) the
  // oldest expectation is compared against data_out.
  always @(posedge clk or chk_now) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (data_out === e.v) passed++;
      else $display("FAIL %s: data_out=%h expected %h", e.n, data_out, e.v);
    end
  end

  // Drive one cycle of inputs mid-cycle; expectation is checked after the
  // next rising edge.
  task automatic op(input logic en, input logic we, input int a,
                    input int d, input int ev, input string n);
    exp_t e;
    @(negedge clk);
    core_en = en; wr_en = we; addr = a[AW-1:0]; data_in = d[DW-1:0];
    e.v = ev[DW-1:0]; e.n = n;
    sb.push_back(e);
  endtask

  task automatic check_now(input int ev, input string n);
    exp_t e;
    e.v = ev[DW-1:0]; e.n = n;
    sb.push_back(e);
    -> chk_now;
  endtask

  initial begin
    // reset held 3 cycles with an enabled read of addr 5
    op(1, 0, 5, 0, 0, "rst_c0");
    op(1, 0, 5, 0, 0, "rst_c1");
    op(1, 0, 5, 0, 0, "rst_c2");
    @(negedge clk); rst_n = 1'b1;
    core_en = 1'b0;
    op(0, 0, 5, 0, 0, "post_rst_idle");
    op(1, 0, 5, 0, 0, "post_rst_rd5");

    // write-first and read-back
    op(1, 1, 22, 3456, 3456, "wr22_first");
    op(1, 0, 0,  0,    0,    "rd0");
    op(1, 0, 22, 0,    3456, "rd22");

    // enable gating
    op(0, 1, 22, 'hFFFFF, 3456, "dis_hold");
    op(1, 0, 22, 0,       3456, "rd22_after_dis");

    // address extremes
    op(1, 1, 0,    'h00001, 'h00001, "wr0");
    op(1, 1, 4095, 'hABCDE, 'hABCDE, "wr4095");
    op(1, 0, 0,    0,       'h00001, "rd0_ext");
    op(1, 0, 4095, 0,       'hABCDE, "rd4095_ext");

    // back-to-back writes then reads
    op(1, 1, 100, 10, 10, "wr100");
    op(1, 1, 101, 11, 11, "wr101");
    op(1, 1, 102, 12, 12, "wr102");
    op(1, 0, 100, 0,  10, "rd100");
    op(1, 0, 101, 0,  11, "rd101");
    op(1, 0, 102, 0,  12, "rd102");

    // async reset between edges while data_out=12
    @(posedge clk); #3;
    rst_n = 1'b0;
    check_now(0, "async_rst_imm");
    op(1, 1, 200, 77, 0, "wr_in_rst");
    @(negedge clk); rst_n = 1'b1;
    core_en = 1'b0;
    op(0, 0, 0,   0, 0,  "post_rst2_idle");
    op(1, 0, 200, 0, 0,  "rd200_dropped");
    op(1, 0, 102, 0, 12, "rd102_kept");
    op(0, 0, 0,   0, 12, "final_hold");

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
